// File: rtl/svd_rotation_angle_sequencer.sv
// Sequencer for the 2x2 SVD rotation-angle step-1 datapath: latches a block, captures
// N/D/K/sign, runs two restoring dividers. Optional perf counters: SVD_SEQ_PERF_CNT_EN.
module svd_rotation_angle_sequencer #(
   parameter int unsigned WORD_LENGTH = 16,
   parameter int unsigned FRAC_BITS   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_LENGTH-1:0] in_a,
   input  logic [WORD_LENGTH-1:0] in_b,
   input  logic [WORD_LENGTH-1:0] in_c,
   input  logic [WORD_LENGTH-1:0] in_d,
   input  logic                   flush,
   output logic [WORD_LENGTH-1:0] dp_a,
   output logic [WORD_LENGTH-1:0] dp_b,
   output logic [WORD_LENGTH-1:0] dp_c,
   output logic [WORD_LENGTH-1:0] dp_d,
   input  logic [WORD_LENGTH-1:0] dp_n1,
   input  logic [WORD_LENGTH-1:0] dp_d1,
   input  logic [WORD_LENGTH-1:0] dp_n2,
   input  logic [WORD_LENGTH-1:0] dp_d2,
   input  logic [WORD_LENGTH-1:0] dp_k1,
   input  logic [WORD_LENGTH-1:0] dp_k2,
   input  logic [1:0]             dp_s1,
   input  logic [1:0]             dp_s2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FRAC_BITS-1:0]   q1,
   output logic [FRAC_BITS-1:0]   q2,
   output logic                   neg1,
   output logic                   neg2,
   output logic                   sat1,
   output logic                   sat2,
   output logic [WORD_LENGTH-1:0] k1,
   output logic [WORD_LENGTH-1:0] k2,
   output logic                   busy
`ifdef SVD_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]            perf_blocks,
   output logic [31:0]            perf_stall
`endif
);

   localparam int unsigned W     = WORD_LENGTH;
   localparam int unsigned RW    = WORD_LENGTH + 1;
   localparam int unsigned TW    = WORD_LENGTH + 2;
   localparam int unsigned CNT_W = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP1 = 2'd1,
      ITER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic               accept_c;
   logic               release_c;
   logic [CNT_W-1:0]   cnt;
   logic [W-1:0]       den1;
   logic [W-1:0]       den2;
   logic [RW-1:0]      rem1;
   logic [RW-1:0]      rem2;
   logic [FRAC_BITS-1:0] qacc1;
   logic [FRAC_BITS-1:0] qacc2;
   logic [RW:0]        step1_c;
   logic [RW:0]        step2_c;
   logic [FRAC_BITS-1:0] nq1_c;
   logic [FRAC_BITS-1:0] nq2_c;
   logic               unused_sign_msbs;

   // Only bit 0 of each sign-xor pair defines the ratio sign.
   assign unused_sign_msbs = ^{dp_s1[1], dp_s2[1]};

   // One restoring-division step: returns {quotient_bit, new_remainder}.
   // A zero divisor never produces a 1 so that 0/0 yields a zero quotient.
   function automatic logic [RW:0] div_step(input logic [RW-1:0] r, input logic [W-1:0] d);
      logic [TW-1:0] t;
      t = {r, 1'b0};
      if ((d != '0) && (t >= TW'(d)))
         return {1'b1, RW'(t - TW'(d))};
      else
         return {1'b0, RW'(t)};
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; flush overrides every handshake.
   always_comb begin
      next_state = state;
      accept_c   = 1'b0;
      release_c  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               next_state = STEP1;
               accept_c   = 1'b1;
            end
         end
         STEP1: next_state = ITER;
         ITER: begin
            if (cnt == '0)
               next_state = DONE;
         end
         DONE: begin
            if (out_ready) begin
               next_state = IDLE;
               release_c  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      if (flush) begin
         next_state = IDLE;
         accept_c   = 1'b0;
         release_c  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (next_state == IDLE);
         out_valid <= (next_state == DONE);
         busy      <= (next_state != IDLE);
      end
   end

   // Operand registers drive the external datapath directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_a <= '0;
         dp_b <= '0;
         dp_c <= '0;
         dp_d <= '0;
      end else if (accept_c) begin
         dp_a <= in_a;
         dp_b <= in_b;
         dp_c <= in_c;
         dp_d <= in_d;
      end
   end

   assign step1_c = div_step(rem1, den1);
   assign step2_c = div_step(rem2, den2);
   assign nq1_c   = FRAC_BITS'({qacc1, step1_c[RW]});
   assign nq2_c   = FRAC_BITS'({qacc2, step2_c[RW]});

   // Datapath capture and the two dividers; results land in q1/q2 on the last step.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         den1  <= '0;
         den2  <= '0;
         rem1  <= '0;
         rem2  <= '0;
         qacc1 <= '0;
         qacc2 <= '0;
         q1    <= '0;
         q2    <= '0;
         neg1  <= 1'b0;
         neg2  <= 1'b0;
         sat1  <= 1'b0;
         sat2  <= 1'b0;
         k1    <= '0;
         k2    <= '0;
      end else begin
         case (state)
            STEP1: begin
               den1  <= dp_d1;
               den2  <= dp_d2;
               rem1  <= {1'b0, dp_n1};
               rem2  <= {1'b0, dp_n2};
               qacc1 <= '0;
               qacc2 <= '0;
               sat1  <= (dp_n1 >= dp_d1) && !((dp_n1 == '0) && (dp_d1 == '0));
               sat2  <= (dp_n2 >= dp_d2) && !((dp_n2 == '0) && (dp_d2 == '0));
               neg1  <= dp_s1[0];
               neg2  <= dp_s2[0];
               k1    <= dp_k1;
               k2    <= dp_k2;
               cnt   <= CNT_W'(FRAC_BITS - 1);
            end
            ITER: begin
               rem1  <= step1_c[RW-1:0];
               rem2  <= step2_c[RW-1:0];
               qacc1 <= nq1_c;
               qacc2 <= nq2_c;
               if (cnt == '0) begin
                  q1 <= sat1 ? '1 : nq1_c;
                  q2 <= sat2 ? '1 : nq2_c;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SVD_SEQ_PERF_CNT_EN
   // Free-running activity counters; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_blocks <= '0;
         perf_stall  <= '0;
      end else begin
         if (release_c)
            perf_blocks <= perf_blocks + 32'd1;
         if ((state == DONE) && !out_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_svd_rotation_angle_sequencer.sv
// Self-checking bench for svd_rotation_angle_sequencer; the bench plays the external
// step-1 datapath and predicts ratios with plain integer division.
module tb_svd_rotation_angle_sequencer;

   localparam int unsigned W = 16;
   localparam int unsigned F = 8;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
   logic [W-1:0] in_a, in_b, in_c, in_d, dp_a, dp_b, dp_c, dp_d;
   logic [W-1:0] dp_n1, dp_d1, dp_n2, dp_d2, dp_k1, dp_k2, k1, k2;
   logic [1:0]   dp_s1, dp_s2;
   logic [F-1:0] q1, q2;
   logic         neg1, neg2, sat1, sat2;
`ifdef SVD_SEQ_PERF_CNT_EN
   logic [31:0]  perf_blocks, perf_stall;
`endif

   int n_vec = 0;
   int n_err = 0;
   int exp_blocks = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   svd_rotation_angle_sequencer #(.WORD_LENGTH(W), .FRAC_BITS(F)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .flush(flush),
      .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
      .dp_n1(dp_n1), .dp_d1(dp_d1), .dp_n2(dp_n2), .dp_d2(dp_d2),
      .dp_k1(dp_k1), .dp_k2(dp_k2), .dp_s1(dp_s1), .dp_s2(dp_s2),
      .out_valid(out_valid), .out_ready(out_ready), .q1(q1), .q2(q2),
      .neg1(neg1), .neg2(neg2), .sat1(sat1), .sat2(sat2), .k1(k1), .k2(k2),
      .busy(busy)
`ifdef SVD_SEQ_PERF_CNT_EN
      , .perf_blocks(perf_blocks), .perf_stall(perf_stall)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference ratio: floor(N * 2^F / D) for N < D, all-ones when saturated, 0 for 0/0.
   function automatic logic [F-1:0] ref_q(input logic [W-1:0] n, input logic [W-1:0] d);
      longint unsigned nn, dd;
      nn = longint'(n);
      dd = longint'(d);
      if (n == 0 && d == 0) return '0;
      if (n >= d) return '1;
      return F'((nn << F) / dd);
   endfunction

   function automatic logic ref_sat(input logic [W-1:0] n, input logic [W-1:0] d);
      return (n >= d) && !(n == 0 && d == 0);
   endfunction

   task automatic drive_junk();
      dp_n1 = W'($urandom); dp_d1 = W'($urandom); dp_n2 = W'($urandom);
      dp_d2 = W'($urandom); dp_k1 = W'($urandom); dp_k2 = W'($urandom);
      dp_s1 = 2'($urandom); dp_s2 = 2'($urandom);
   endtask

   task automatic check_perf();
`ifdef SVD_SEQ_PERF_CNT_EN
      chk("perf_blocks", perf_blocks, 64'(exp_blocks));
      chk("perf_stall", perf_stall, 64'(exp_stall));
`endif
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_q_flags"}, {q1, q2, neg1, neg2, sat1, sat2}, 0);
      chk({tag, "_k"}, {k1, k2}, 0);
      chk({tag, "_dp"}, {dp_a, dp_b, dp_c, dp_d}, 0);
      check_perf();
   endtask

   // Accept one block, feed the datapath values in STEP1 only, and check the result.
   task automatic run_block(input logic [W-1:0] n1, d1, n2, d2, kk1, kk2,
                            input logic [1:0] s1, s2, input int stall, input bit rst_in_done);
      logic [W-1:0] a, b, c, d;
      logic [F-1:0] eq1, eq2;
      int waited;
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      waited = 0;
      while (!in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_d = d;
      @(negedge clk);
      in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
      dp_n1 = n1; dp_d1 = d1; dp_n2 = n2; dp_d2 = d2;
      dp_k1 = kk1; dp_k2 = kk2; dp_s1 = s1; dp_s2 = s2;
      chk("dp_operands", {dp_a, dp_b, dp_c, dp_d}, {a, b, c, d});
      chk("busy_step1", busy, 1);
      chk("in_ready_busy", in_ready, 0);
      @(negedge clk);
      drive_junk();
      for (int i = 0; i < int'(F); i++) begin
         chk("out_valid_early", out_valid, 0);
         @(negedge clk);
      end
      eq1 = ref_q(n1, d1);
      eq2 = ref_q(n2, d2);
      chk("out_valid_done", out_valid, 1);
      chk("q1", q1, eq1);
      chk("q2", q2, eq2);
      chk("sat", {sat1, sat2}, {ref_sat(n1, d1), ref_sat(n2, d2)});
      chk("neg", {neg1, neg2}, {s1[0], s2[0]});
      chk("k", {k1, k2}, {kk1, kk2});
      if (rst_in_done) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         exp_blocks = 0;
         exp_stall = 0;
         check_reset_state("rst_done");
         return;
      end
      exp_stall += stall + 0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_hold", {out_valid, in_ready, q1, q2, sat1, sat2}, {1'b1, 1'b0, eq1, eq2,
             ref_sat(n1, d1), ref_sat(n2, d2)});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_blocks++;
      chk("post_hs", {out_valid, in_ready, busy}, 3'b010);
      check_perf();
   endtask

   initial begin
      logic [W-1:0] rn1, rd1, rn2, rd2;
      int accepts[$];
      int outs;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_d = '0;
      drive_junk();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // Directed ratios from the plan.
      run_block(16'd1, 16'd4, 16'd3, 16'd4, 16'h0003, 16'h0011, 2'b01, 2'b00, 0, 1'b0);
      run_block(16'd5, 16'd5, 16'd7, 16'd0, 16'h1234, 16'h00FF, 2'b10, 2'b11, 5, 1'b0);
      run_block(16'd0, 16'd0, 16'd1, 16'd3, 16'h0000, 16'h8000, 2'b00, 2'b01, 1, 1'b0);

      // Flush in IDLE rejects the operands.
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("idle_flush", {busy, in_ready}, 2'b01);

      // Flush in the third ITER cycle.
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      dp_n1 = 16'd1; dp_d1 = 16'd2; dp_n2 = 16'd1; dp_d2 = 16'd2;
      @(negedge clk);
      drive_junk();
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", {busy, in_ready, out_valid}, 3'b010);
      for (int i = 0; i < 12; i++) begin
         chk("flush_no_valid", out_valid, 0);
         @(negedge clk);
      end
      check_perf();
      run_block(16'd2, 16'd3, 16'd100, 16'd999, 16'h0003, 16'h0004, 2'b11, 2'b10, 0, 1'b0);

      // Reset while a result is pending.
      run_block(16'd9, 16'd10, 16'd4, 16'd2, 16'h0FFF, 16'h0001, 2'b01, 2'b01, 0, 1'b1);

      // Back-to-back blocks with in_valid and out_ready held high.
      dp_n1 = 16'd1; dp_d1 = 16'd3; dp_n2 = 16'd2; dp_d2 = 16'd5;
      dp_k1 = 16'h0003; dp_k2 = 16'h0007; dp_s1 = 2'b01; dp_s2 = 2'b10;
      in_valid = 1'b1; out_ready = 1'b1;
      outs = 0;
      for (int c = 0; c < 33; c++) begin
         if (in_ready) accepts.push_back(c);
         if (out_valid) begin
            outs++;
            exp_blocks++;
            chk("b2b_result", {q1, q2, k1, neg1, neg2},
                {ref_q(16'd1, 16'd3), ref_q(16'd2, 16'd5), 16'h0003, 1'b1, 1'b0});
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_accept_count", 64'(accepts.size()), 3);
      if (accepts.size() == 3)
         chk("b2b_accept_cycles", {32'(accepts[1] - accepts[0]), 32'(accepts[2] - accepts[0])},
             {32'd11, 32'd22});
      chk("b2b_out_count", 64'(outs), 3);
      check_perf();

      // Randomized blocks across operand classes.
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0: begin rn1 = W'($urandom); rd1 = W'($urandom); end
            1: begin rd1 = W'($urandom_range(1, 65535)); rn1 = W'($urandom_range(0, int'(rd1) - 1)); end
            2: begin rn1 = '0; rd1 = '0; end
            default: begin rn1 = W'($urandom_range(1, 65535)); rd1 = '0; end
         endcase
         rd2 = W'($urandom_range(1, 65535));
         rn2 = W'($urandom_range(0, int'(rd2) - 1));
         run_block(rn1, rd1, rn2, rd2, W'($urandom), W'($urandom), 2'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/svd_rotation_angle_sequencer.md
Name: svd_rotation_angle_sequencer

Overview:
- Controller that sequences the 2x2 SVD rotation-angle step-1 datapath for one 2x2 block (a,b,c,d) at a time.
- Latches an operand set via valid/ready, drives it onto the external step-1 datapath and captures its N/D/K/sign outputs.
- Runs two parallel restoring dividers (N1/D1, N2/D2) to produce fixed-point tangent ratios.
- Presents results downstream via valid/ready. Sits between the block-fetch unit and the angle-lookup/rotation stage.

Parameters:
WORD_LENGTH, 16, width of operands and of every datapath word
FRAC_BITS, 8, fractional quotient bits per ratio; also the divide-iteration count (1..WORD_LENGTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operands
in_a, in_b, in_c, in_d  in  WORD_LENGTH each  2x2 block elements, two's complement
flush  in  1  synchronous abort of any in-flight block
dp_a, dp_b, dp_c, dp_d  out  WORD_LENGTH each  operands to step-1 datapath
dp_n1, dp_d1, dp_n2, dp_d2  in  WORD_LENGTH each  datapath magnitudes
dp_k1, dp_k2  in  WORD_LENGTH each  datapath exponent differences
dp_s1, dp_s2  in  2 each  datapath sign-xor results (D1xorN1, D2xorN2)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
q1, q2  out  FRAC_BITS each  N1/D1 and N2/D2 ratio, unsigned fraction
neg1, neg2  out  1 each  ratio sign = bit 0 of dp_s1 / dp_s2
sat1, sat2  out  1 each  ratio saturated (N >= D, or D == 0 with N != 0)
k1, k2  out  WORD_LENGTH each  captured dp_k1 / dp_k2, passed through
busy  out  1  state != IDLE

Behaviour:
- Only one clock; every register updates on the rising edge of clk. rst is synchronous and active-high; there is no asynchronous reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0. q1, q2, neg1, neg2, sat1, sat2, k1, k2, dp_a..dp_d all 0. Iteration counter 0.
- FSM states: IDLE, STEP1, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready (cycle T): register a, b, c, d; go to STEP1.
- STEP1 (cycle T+1):
  - dp_a..dp_d driven from the operand registers. They are registered, so they are stable for the whole state. The datapath is purely combinational.
  - At the end of the cycle, capture dp_n*, dp_d*, dp_k*, dp_s*.
  - Initialise remainder r_i = {1'b0, N_i} (WORD_LENGTH+1 bits) and quotient = 0.
  - Set sat_i = (N_i >= D_i) && !(N_i == 0 && D_i == 0).
  - Set counter = FRAC_BITS-1; go to ITER.
- ITER: exactly FRAC_BITS cycles.
  - Each cycle, per channel: t = r << 1. If t >= D then r = t - D and shift in 1; else r = t and shift in 0. Quotient bits are produced MSB first.
  - On counter == 0: go to DONE; otherwise decrement the counter.
  - Saturated channels ignore the quotient; they present all-ones at output.
- DONE:
  - out_valid=1 from cycle T+2+FRAC_BITS.
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE. in_ready is 1 in the cycle after the handshake.
  - No overlap between blocks; throughput is 1 block per FRAC_BITS+3 cycles, or more with back-pressure.
- N == 0 and D == 0: q=0, sat=0.
- flush: forces IDLE next cycle from any state.
  - Drops the in-flight block; out_valid=0.
  - Result registers keep stale values and are not to be used.
  - flush has priority over an in/out handshake in the same cycle. In IDLE, flush with in_valid rejects the operands.
- rst mid-operation: identical to flush, and additionally clears every register to its reset value.
- in_valid while busy is ignored (in_ready=0). Upstream holds its data.

Optional Feature:
SVD_SEQ_PERF_CNT_EN
- Defined: adds outputs perf_blocks (32 bits) and perf_stall (32 bits).
  - perf_blocks increments on each out handshake.
  - perf_stall increments each cycle in DONE with !out_ready.
  - Both wrap at 2^32, are cleared by rst, and are not cleared by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single block, N1=1, D1=4, N2=3, D2=4, s1=2'b01, s2=0, FRAC_BITS=8 -> out_valid at T+10; q1=0x40, neg1=1, sat1=0; q2=0xC0, neg2=0.
- N1=5, D1=5, and N2=7, D2=0 -> sat1=1, q1=0xFF; sat2=1, q2=0xFF. N=0, D=0 case -> q=0, sat=0.
- out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0; in_ready=1 the cycle after the handshake. perf_stall=5 when the macro is enabled.
- flush asserted in the 3rd ITER cycle -> IDLE next cycle, out_valid never asserts. A following block completes correctly at T'+10.
- rst asserted in DONE with out_valid=1 -> next cycle out_valid=0, all outputs 0, in_ready=1.
- 3 back-to-back blocks with in_valid and out_ready held high -> accepts at cycles 0, 11, 22 (FRAC_BITS=8). dp_k1 = 0x0003 is passed through as k1=0x0003.
